// File: rtl/ram_arb_defs.sv
// Shared definitions for the fetch/data RAM arbiter: FSM encodings, data
// lengths, port identifiers, the latched RAM command and the grant rule.
package ram_arb_defs;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] DL_BYTE = 2'b00;
  localparam logic [1:0] DL_HALF = 2'b01;
  localparam logic [1:0] DL_WORD = 2'b10;
  localparam logic [1:0] DL_RSVD = 2'b11;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

  typedef struct packed {
    logic        rw;
    logic        sig;
    logic [1:0]  dl;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } ram_cmd_t;

  // Lone requester wins; under contention the port not granted last time wins.
  function automatic logic pick_port(input logic if_req, input logic dm_req,
                                     input logic last_grant);
    if (if_req && dm_req) return (last_grant == PORT_DM) ? PORT_IF : PORT_DM;
    if (dm_req)           return PORT_DM;
    return PORT_IF;
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single RAM with
// a MOC handshake, per-access timeout and a sticky abort flag.
module ram_arbiter
  import ram_arb_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        main_clk,
  input  logic        reset,

  input  logic        if_req,
  input  logic [8:0]  if_addr,
  output logic        if_done,

  input  logic        dm_req,
  input  logic        dm_rw,
  input  logic        dm_sig,
  input  logic [1:0]  dm_dl,
  input  logic [8:0]  dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_done,

  output logic [31:0] rdata,

  output logic        ram_mov,
  output logic        ram_rw,
  output logic        ram_sig,
  output logic [1:0]  ram_dl,
  output logic [8:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_moc,
  input  logic [31:0] ram_rdata,

  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic       grant;
  logic       last_grant;
  logic [7:0] wait_cnt;
  ram_cmd_t   cmd;
  ram_cmd_t   next_cmd;
  logic       winner;

  // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    winner   = pick_port(if_req, dm_req, last_grant);
    next_cmd = '{rw: 1'b1, sig: 1'b0, dl: DL_WORD, addr: if_addr, wdata: '0};
    if (winner == PORT_DM) begin
      next_cmd = '{rw: dm_rw, sig: dm_sig, dl: dm_dl, addr: dm_addr, wdata: dm_wdata};
      // The reserved length code is issued to the RAM as a plain word access.
      if (dm_dl == DL_RSVD) next_cmd.dl = DL_WORD;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= PORT_IF;
      last_grant  <= PORT_IF;
      wait_cnt    <= '0;
      cmd         <= '0;
      rdata       <= '0;
      ram_mov     <= 1'b0;
      if_done     <= 1'b0;
      dm_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      // A timeout later in this block overrides a simultaneous clear.
      if (err_clr) timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (if_req || dm_req) begin
            grant      <= winner;
            last_grant <= winner;
            cmd        <= next_cmd;
            ram_mov    <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ram_moc) begin
            if (cmd.rw) rdata <= ram_rdata;
            ram_mov <= 1'b0;
            if_done <= (grant == PORT_IF);
            dm_done <= (grant == PORT_DM);
            state   <= ST_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            rdata       <= '0;
            timeout_err <= 1'b1;
            ram_mov     <= 1'b0;
            if_done     <= (grant == PORT_IF);
            dm_done     <= (grant == PORT_DM);
            state       <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign ram_rw    = cmd.rw;
  assign ram_sig   = cmd.sig;
  assign ram_dl    = cmd.dl;
  assign ram_addr  = cmd.addr;
  assign ram_wdata = cmd.wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM with programmable MOC
// delay, scoreboard checked on every done pulse, vector table plus corner cases.
module tb_ram_arbiter;
  import ram_arb_defs::*;

  localparam int TO    = 16;
  localparam int NEVER = 1000;

  logic        main_clk = 1'b0;
  logic        reset    = 1'b0;
  logic        if_req   = 1'b0;
  logic [8:0]  if_addr  = '0;
  logic        if_done;
  logic        dm_req   = 1'b0;
  logic        dm_rw    = 1'b0;
  logic        dm_sig   = 1'b0;
  logic [1:0]  dm_dl    = '0;
  logic [8:0]  dm_addr  = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_done;
  logic [31:0] rdata;
  logic        ram_mov, ram_rw, ram_sig;
  logic [1:0]  ram_dl;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_moc   = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic        busy, timeout_err;
  logic        err_clr = 1'b0;

  always #5 main_clk = ~main_clk;

  ram_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .main_clk(main_clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .dm_req(dm_req), .dm_rw(dm_rw), .dm_sig(dm_sig), .dm_dl(dm_dl),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_done(dm_done),
    .rdata(rdata),
    .ram_mov(ram_mov), .ram_rw(ram_rw), .ram_sig(ram_sig), .ram_dl(ram_dl),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_moc(ram_moc),
    .ram_rdata(ram_rdata),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural RAM: MOC arrives after moc_delay WAIT cycles without it.
  logic [31:0] mem [512];
  int moc_delay = NEVER;
  int mov_cnt   = 0;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hA500_0000 | i;
    mem[4] = 32'hE3A0_1005;
  end

  always @(negedge main_clk) begin
    if (ram_mov) mov_cnt = mov_cnt + 1;
    else         mov_cnt = 0;
    ram_moc   = ram_mov && (mov_cnt == moc_delay + 2);
    ram_rdata = ram_moc ? mem[ram_addr] : 32'h0BAD_F00D;
    if (ram_moc && !ram_rw) mem[ram_addr] = ram_wdata;
  end

  // Scoreboard: one entry per expected done pulse.
  typedef struct {
    logic        port;
    logic        rw;
    logic        sig;
    logic [1:0]  dl;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  exp_t sb_q[$];

  always @(negedge main_clk) begin
    exp_t e;
    if (!reset && (if_done || dm_done)) begin
      check("single_done", {31'b0, if_done & dm_done}, 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: if_done=%b dm_done=%b, expected no pulse", if_done, dm_done);
      end else begin
        e = sb_q.pop_front();
        check("done_port",   {31'b0, dm_done},      {31'b0, e.port});
        check("rdata",       rdata,                 e.rdata);
        check("ram_rw",      {31'b0, ram_rw},       {31'b0, e.rw});
        check("ram_sig",     {31'b0, ram_sig},      {31'b0, e.sig});
        check("ram_dl",      {30'b0, ram_dl},       {30'b0, e.dl});
        check("ram_addr",    {23'b0, ram_addr},     {23'b0, e.addr});
        if (!e.rw) check("ram_wdata", ram_wdata, e.wdata);
        check("timeout_err", {31'b0, timeout_err},  {31'b0, e.to});
        check("mov_in_done", {31'b0, ram_mov},      32'd0);
        check("busy_in_done",{31'b0, busy},         32'd1);
      end
    end
  end

  typedef struct {
    logic        port;
    logic        rw;
    logic        sig;
    logic [1:0]  dl;
    logic [8:0]  addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] exp_rdata;
    logic        exp_to;
  } vec_t;

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.port  = v.port;
    e.rw    = (v.port == PORT_IF) ? 1'b1 : v.rw;
    e.sig   = (v.port == PORT_IF) ? 1'b0 : v.sig;
    e.dl    = (v.port == PORT_IF || v.dl == 2'b11) ? 2'b10 : v.dl;
    e.addr  = v.addr;
    e.wdata = v.wdata;
    e.rdata = v.exp_rdata;
    e.to    = v.exp_to;
    return e;
  endfunction

  // Runs one access; port inputs are scrambled after grant to prove they are ignored.
  task automatic do_txn(input vec_t v);
    int   cyc;
    int   exp_lat;
    logic seen;
    @(negedge main_clk);
    moc_delay = v.delay;
    sb_q.push_back(mk_exp(v));
    if (v.port == PORT_IF) begin
      if_addr = v.addr;
      if_req  = 1'b1;
    end else begin
      dm_rw = v.rw; dm_sig = v.sig; dm_dl = v.dl; dm_addr = v.addr; dm_wdata = v.wdata;
      dm_req = 1'b1;
    end
    exp_lat = (v.delay >= TO) ? TO + 2 : v.delay + 3;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge main_clk);
      cyc++;
      if ((v.port == PORT_IF) ? if_done : dm_done) seen = 1'b1;
      else if (cyc == 1) begin
        if_addr  = if_addr ^ 9'h1AA;
        dm_addr  = dm_addr ^ 9'h155;
        dm_wdata = ~dm_wdata;
        dm_rw    = ~dm_rw;
        dm_sig   = ~dm_sig;
        dm_dl    = dm_dl ^ 2'b11;
      end
    end
    if (v.port == PORT_IF) if_req = 1'b0;
    else                   dm_req = 1'b0;
    check("latency", cyc, exp_lat);
  endtask

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{PORT_IF, 1'b1, 1'b0, DL_WORD, 9'h004, 32'h0,         2,     32'hE3A0_1005, 1'b0};
    vecs[1]  = '{PORT_DM, 1'b0, 1'b0, DL_HALF, 9'h010, 32'h1234_5678, 0,     32'hE3A0_1005, 1'b0};
    vecs[2]  = '{PORT_DM, 1'b1, 1'b0, DL_WORD, 9'h010, 32'h0,         1,     32'h1234_5678, 1'b0};
    vecs[3]  = '{PORT_DM, 1'b1, 1'b1, DL_BYTE, 9'h1FF, 32'h0,         3,     32'hA500_01FF, 1'b0};
    vecs[4]  = '{PORT_DM, 1'b1, 1'b0, 2'b11,   9'h000, 32'h0,         0,     32'hA500_0000, 1'b0};
    vecs[5]  = '{PORT_IF, 1'b1, 1'b0, DL_WORD, 9'h100, 32'h0,         0,     32'hA500_0100, 1'b0};
    vecs[6]  = '{PORT_DM, 1'b0, 1'b0, DL_BYTE, 9'h1FF, 32'hDEAD_BEEF, 5,     32'hA500_0100, 1'b0};
    vecs[7]  = '{PORT_IF, 1'b1, 1'b0, DL_WORD, 9'h1FF, 32'h0,         1,     32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{PORT_DM, 1'b1, 1'b0, DL_WORD, 9'h100, 32'h0,         TO-1,  32'hA500_0100, 1'b0};
    vecs[9]  = '{PORT_IF, 1'b1, 1'b0, DL_WORD, 9'h020, 32'h0,         NEVER, 32'h0,         1'b1};
    vecs[10] = '{PORT_DM, 1'b1, 1'b0, DL_WORD, 9'h004, 32'h0,         0,     32'hE3A0_1005, 1'b1};

    // Reset state
    #2 reset = 1'b1;
    #1;
    check("rst_if_done", {31'b0, if_done},     32'd0);
    check("rst_dm_done", {31'b0, dm_done},     32'd0);
    check("rst_rdata",   rdata,                32'd0);
    check("rst_ram_mov", {31'b0, ram_mov},     32'd0);
    check("rst_busy",    {31'b0, busy},        32'd0);
    check("rst_to_err",  {31'b0, timeout_err}, 32'd0);
    check("rst_ram_ctl", {18'b0, ram_rw, ram_sig, ram_dl, ram_addr}, 32'd0);
    check("rst_wdata",   ram_wdata,            32'd0);
    repeat (3) @(negedge main_clk);
    reset = 1'b0;

    // Contention right after reset: dm first, then strict alternation every 4 cycles
    begin
      int cyc, last, n;
      @(negedge main_clk);
      moc_delay = 0;
      sb_q.push_back('{PORT_DM, 1'b1, 1'b0, DL_WORD, 9'h008, 32'h0, 32'hA500_0008, 1'b0});
      sb_q.push_back('{PORT_IF, 1'b1, 1'b0, DL_WORD, 9'h00C, 32'h0, 32'hA500_000C, 1'b0});
      sb_q.push_back('{PORT_DM, 1'b1, 1'b0, DL_WORD, 9'h008, 32'h0, 32'hA500_0008, 1'b0});
      sb_q.push_back('{PORT_IF, 1'b1, 1'b0, DL_WORD, 9'h00C, 32'h0, 32'hA500_000C, 1'b0});
      dm_rw = 1'b1; dm_sig = 1'b0; dm_dl = DL_WORD; dm_addr = 9'h008;
      if_addr = 9'h00C;
      dm_req = 1'b1;
      if_req = 1'b1;
      cyc = 0; last = 0; n = 0;
      while (n < 4 && cyc < 100) begin
        @(negedge main_clk);
        cyc++;
        if (if_done || dm_done) begin
          n++;
          if (n == 1) check("first_latency", cyc, 3);
          else        check("b2b_gap", cyc - last, 4);
          last = cyc;
        end
      end
      dm_req = 1'b0;
      if_req = 1'b0;
      check("contention_dones", n, 4);
    end

    for (int i = 0; i < 11; i++) do_txn(vecs[i]);

    // Sticky flag cleared by err_clr
    @(negedge main_clk);
    err_clr = 1'b1;
    @(negedge main_clk);
    err_clr = 1'b0;
    check("err_clr", {31'b0, timeout_err}, 32'd0);

    // err_clr held through a timeout: the new abort wins on the shared edge
    err_clr = 1'b1;
    do_txn('{PORT_DM, 1'b0, 1'b0, DL_WORD, 9'h030, 32'hCAFE_0000, NEVER, 32'h0, 1'b1});
    err_clr = 1'b0;
    @(negedge main_clk);
    check("err_sticky", {31'b0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    @(negedge main_clk);
    err_clr = 1'b0;
    check("err_clr2", {31'b0, timeout_err}, 32'd0);

    // Request withdrawn before grant: no access, no pulse
    fork
      do_txn('{PORT_IF, 1'b1, 1'b0, DL_WORD, 9'h004, 32'h0, 3, 32'hE3A0_1005, 1'b0});
      begin
        repeat (2) @(negedge main_clk);
        dm_rw = 1'b0; dm_addr = 9'h004; dm_wdata = 32'h5555_AAAA; dm_dl = DL_WORD;
        dm_req = 1'b1;
        repeat (2) @(negedge main_clk);
        dm_req = 1'b0;
      end
    join
    repeat (5) @(negedge main_clk);
    check("withdrawn_idle", {31'b0, busy}, 32'd0);
    check("withdrawn_mem", mem[4], 32'hE3A0_1005);

    // Reset in WAIT: ram_mov drops at once, no done pulse
    @(negedge main_clk);
    moc_delay = NEVER;
    if_addr = 9'h040;
    if_req  = 1'b1;
    repeat (5) @(negedge main_clk);
    check("pre_rst_mov", {31'b0, ram_mov}, 32'd1);
    reset = 1'b1;
    if_req = 1'b0;
    #1;
    check("mid_rst_mov",   {31'b0, ram_mov}, 32'd0);
    check("mid_rst_busy",  {31'b0, busy},    32'd0);
    check("mid_rst_rdata", rdata,            32'd0);
    @(negedge main_clk);
    reset = 1'b0;
    repeat (3) @(negedge main_clk);
    do_txn('{PORT_DM, 1'b1, 1'b1, DL_HALF, 9'h1FF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0});

    repeat (3) @(negedge main_clk);
    check("sb_empty",   sb_q.size(), 32'd0);
    check("final_busy", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
